// File: rtl/prog_loader_if.sv
// Bus between the UART receiver, the program-memory write port and the CPU
// control inputs, as seen by the program loader.
interface prog_loader_if #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 16
);
    logic                   load_start;
    logic [7:0]             rx_data;
    logic                   rx_done;
    logic                   mem_we;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [INSTR_WIDTH-1:0] mem_wdata;
    logic                   cpu_stop;
    logic                   cpu_restart;
    logic                   load_done;
    logic                   load_err;
    logic [ADDR_WIDTH:0]    words_loaded;

    modport slave (
        input  load_start, rx_data, rx_done,
        output mem_we, mem_addr, mem_wdata, cpu_stop, cpu_restart,
               load_done, load_err, words_loaded
    );

    modport master (
        output load_start, rx_data, rx_done,
        input  mem_we, mem_addr, mem_wdata, cpu_stop, cpu_restart,
               load_done, load_err, words_loaded
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: assembles UART bytes (MSB first) into instruction words, writes
// them to program memory from address 0 and holds/restarts the CPU around the load.
module prog_loader #(
    parameter int                     ADDR_WIDTH  = 8,
    parameter int                     INSTR_WIDTH = 16,
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = {INSTR_WIDTH{1'b0}}
) (
    input  logic         i_clk,
    input  logic         i_rst,
    prog_loader_if.slave io_bus
);
    localparam int                    NB        = INSTR_WIDTH / 8;
    localparam int                    CW        = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0]         LAST_BYTE = CW'(NB - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = {ADDR_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RECV   = 3'd1,
        S_WRITE  = 3'd2,
        S_FINISH = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t                 r_state,       w_state_nxt;
    logic [CW-1:0]          r_cnt,         w_cnt_nxt;
    logic [INSTR_WIDTH-1:0] r_word,        w_word_nxt;
    logic [ADDR_WIDTH-1:0]  r_addr,        w_addr_nxt;
    logic                   r_mem_we,      w_mem_we_nxt;
    logic [ADDR_WIDTH-1:0]  r_mem_addr,    w_mem_addr_nxt;
    logic [INSTR_WIDTH-1:0] r_mem_wdata,   w_mem_wdata_nxt;
    logic                   r_cpu_stop,    w_cpu_stop_nxt;
    logic                   r_cpu_restart, w_cpu_restart_nxt;
    logic                   r_load_done,   w_load_done_nxt;
    logic                   r_load_err,    w_load_err_nxt;
    logic [ADDR_WIDTH:0]    r_words,       w_words_nxt;

    // Widened concatenation keeps the shift legal even when a word is a single byte.
    logic [INSTR_WIDTH+7:0] w_ext;
    logic [INSTR_WIDTH-1:0] w_shifted;
    assign w_ext     = {r_word, io_bus.rx_data};
    assign w_shifted = w_ext[INSTR_WIDTH-1:0];

    // Next-state and next-output decode; load_start overrides every state.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_word_nxt        = r_word;
        w_addr_nxt        = r_addr;
        w_mem_we_nxt      = 1'b0;
        w_mem_addr_nxt    = r_mem_addr;
        w_mem_wdata_nxt   = r_mem_wdata;
        w_cpu_stop_nxt    = r_cpu_stop;
        w_cpu_restart_nxt = 1'b0;
        w_load_done_nxt   = r_load_done;
        w_load_err_nxt    = r_load_err;
        w_words_nxt       = r_words;

        if (io_bus.load_start) begin
            w_state_nxt     = S_RECV;
            w_cnt_nxt       = {CW{1'b0}};
            w_word_nxt      = {INSTR_WIDTH{1'b0}};
            w_addr_nxt      = {ADDR_WIDTH{1'b0}};
            w_cpu_stop_nxt  = 1'b1;
            w_load_done_nxt = 1'b0;
            w_load_err_nxt  = 1'b0;
            w_words_nxt     = {(ADDR_WIDTH+1){1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_cpu_stop_nxt = 1'b0;
                end
                S_RECV: begin
                    if (io_bus.rx_done) begin
                        w_word_nxt = w_shifted;
                        if (r_cnt == LAST_BYTE) begin
                            w_cnt_nxt       = {CW{1'b0}};
                            w_state_nxt     = S_WRITE;
                            w_mem_we_nxt    = 1'b1;
                            w_mem_addr_nxt  = r_addr;
                            w_mem_wdata_nxt = w_shifted;
                            w_words_nxt     = r_words + (ADDR_WIDTH+1)'(1);
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                end
                S_WRITE: begin
                    // Full check precedes the increment so the address never wraps.
                    if (r_word == HALT_WORD) begin
                        w_state_nxt       = S_FINISH;
                        w_cpu_restart_nxt = 1'b1;
                    end else if (r_addr == ADDR_MAX) begin
                        w_state_nxt    = S_ERROR;
                        w_load_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_RECV;
                        w_addr_nxt  = r_addr + ADDR_WIDTH'(1);
                    end
                end
                S_FINISH: begin
                    w_state_nxt     = S_IDLE;
                    w_cpu_stop_nxt  = 1'b0;
                    w_load_done_nxt = 1'b1;
                end
                S_ERROR: begin
                    w_state_nxt = S_ERROR;
                end
                default: begin
                    w_state_nxt    = S_IDLE;
                    w_cpu_stop_nxt = 1'b0;
                end
            endcase
        end
    end

    // State and registered-output update with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= {CW{1'b0}};
            r_word        <= {INSTR_WIDTH{1'b0}};
            r_addr        <= {ADDR_WIDTH{1'b0}};
            r_mem_we      <= 1'b0;
            r_mem_addr    <= {ADDR_WIDTH{1'b0}};
            r_mem_wdata   <= {INSTR_WIDTH{1'b0}};
            r_cpu_stop    <= 1'b0;
            r_cpu_restart <= 1'b0;
            r_load_done   <= 1'b0;
            r_load_err    <= 1'b0;
            r_words       <= {(ADDR_WIDTH+1){1'b0}};
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_word        <= w_word_nxt;
            r_addr        <= w_addr_nxt;
            r_mem_we      <= w_mem_we_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_mem_wdata   <= w_mem_wdata_nxt;
            r_cpu_stop    <= w_cpu_stop_nxt;
            r_cpu_restart <= w_cpu_restart_nxt;
            r_load_done   <= w_load_done_nxt;
            r_load_err    <= w_load_err_nxt;
            r_words       <= w_words_nxt;
        end
    end

    assign io_bus.mem_we       = r_mem_we;
    assign io_bus.mem_addr     = r_mem_addr;
    assign io_bus.mem_wdata    = r_mem_wdata;
    assign io_bus.cpu_stop     = r_cpu_stop;
    assign io_bus.cpu_restart  = r_cpu_restart;
    assign io_bus.load_done    = r_load_done;
    assign io_bus.load_err     = r_load_err;
    assign io_bus.words_loaded = r_words;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a default instance (8-bit address) and a
// 4-bit-address instance used for the memory-full case.
module tb_prog_loader;
    logic clk;
    logic rst;

    prog_loader_if #(.ADDR_WIDTH(8), .INSTR_WIDTH(16)) pl8 ();
    prog_loader_if #(.ADDR_WIDTH(4), .INSTR_WIDTH(16)) pl4 ();

    prog_loader #(.ADDR_WIDTH(8), .INSTR_WIDTH(16), .HALT_WORD(16'h0000)) dut8 (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (pl8.slave)
    );

    prog_loader #(.ADDR_WIDTH(4), .INSTR_WIDTH(16), .HALT_WORD(16'h0000)) dut4 (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (pl4.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] log8[$];
    logic [31:0] log4[$];
    int restarts8 = 0;
    int restarts4 = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write/restart monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (pl8.mem_we) log8.push_back({8'h00, pl8.mem_addr, pl8.mem_wdata});
        if (pl4.mem_we) log4.push_back({12'h000, pl4.mem_addr, pl4.mem_wdata});
        if (pl8.cpu_restart) restarts8++;
        if (pl4.cpu_restart) restarts4++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start8();
        pl8.load_start = 1'b1;
        @(negedge clk);
        pl8.load_start = 1'b0;
    endtask

    task automatic start4();
        pl4.load_start = 1'b1;
        @(negedge clk);
        pl4.load_start = 1'b0;
    endtask

    // Byte strobe followed by one idle cycle so no byte lands in a WRITE cycle.
    task automatic send8(input logic [7:0] b);
        pl8.rx_data = b;
        pl8.rx_done = 1'b1;
        @(negedge clk);
        pl8.rx_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic send4(input logic [7:0] b);
        pl4.rx_data = b;
        pl4.rx_done = 1'b1;
        @(negedge clk);
        pl4.rx_done = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int base;
        int rbase;
        logic [7:0] v;

        rst = 1'b1;
        pl8.load_start = 1'b0; pl8.rx_done = 1'b0; pl8.rx_data = 8'h00;
        pl4.load_start = 1'b0; pl4.rx_done = 1'b0; pl4.rx_data = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_mem_we",    {31'd0, pl8.mem_we},      32'd0);
        check("rst_mem_addr",  {24'd0, pl8.mem_addr},    32'd0);
        check("rst_mem_wdata", {16'd0, pl8.mem_wdata},   32'd0);
        check("rst_cpu_stop",  {31'd0, pl8.cpu_stop},    32'd0);
        check("rst_restart",   {31'd0, pl8.cpu_restart}, 32'd0);
        check("rst_done",      {31'd0, pl8.load_done},   32'd0);
        check("rst_err",       {31'd0, pl8.load_err},    32'd0);
        check("rst_words",     {23'd0, pl8.words_loaded}, 32'd0);

        // Basic load 0x1234, 0x0000 with cycle-exact tail.
        base = log8.size();
        rbase = restarts8;
        start8();
        check("t1_stop_after_start", {31'd0, pl8.cpu_stop}, 32'd1);
        send8(8'h12);
        send8(8'h34);
        send8(8'h00);
        check("t1_stop_mid", {31'd0, pl8.cpu_stop}, 32'd1);
        pl8.rx_data = 8'h00;
        pl8.rx_done = 1'b1;
        @(negedge clk);
        pl8.rx_done = 1'b0;
        check("t1_we_n1",      {31'd0, pl8.mem_we},       32'd1);
        check("t1_addr_n1",    {24'd0, pl8.mem_addr},     32'd1);
        check("t1_wdata_n1",   {16'd0, pl8.mem_wdata},    32'h0000);
        check("t1_restart_n1", {31'd0, pl8.cpu_restart},  32'd0);
        check("t1_words_n1",   {23'd0, pl8.words_loaded}, 32'd2);
        @(negedge clk);
        check("t1_restart_n2", {31'd0, pl8.cpu_restart}, 32'd1);
        check("t1_stop_n2",    {31'd0, pl8.cpu_stop},    32'd1);
        check("t1_we_n2",      {31'd0, pl8.mem_we},      32'd0);
        @(negedge clk);
        check("t1_restart_n3", {31'd0, pl8.cpu_restart},  32'd0);
        check("t1_stop_n3",    {31'd0, pl8.cpu_stop},     32'd0);
        check("t1_done_n3",    {31'd0, pl8.load_done},    32'd1);
        check("t1_words_n3",   {23'd0, pl8.words_loaded}, 32'd2);
        check("t1_nwrites",    log8.size() - base,        32'd2);
        if (log8.size() - base >= 2) begin
            check("t1_write0", log8[base],     32'h0000_1234);
            check("t1_write1", log8[base + 1], 32'h0001_0000);
        end
        check("t1_restarts", restarts8 - rbase, 32'd1);

        // Memory full on the 4-bit-address instance.
        base = log4.size();
        rbase = restarts4;
        start4();
        for (int i = 1; i <= 16; i++) begin
            v = 8'(i);
            send4(v);
            send4(v);
        end
        check("fill_err",     {31'd0, pl4.load_err},     32'd1);
        check("fill_stop",    {31'd0, pl4.cpu_stop},     32'd1);
        check("fill_done",    {31'd0, pl4.load_done},    32'd0);
        check("fill_words",   {27'd0, pl4.words_loaded}, 32'd16);
        check("fill_nwrites", log4.size() - base,        32'd16);
        if (log4.size() - base >= 16) begin
            for (int i = 0; i < 16; i++) begin
                check("fill_write", log4[base + i],
                      {12'h000, 4'(i), 8'(i + 1), 8'(i + 1)});
            end
        end
        send4(8'h77);
        send4(8'h77);
        check("fill_no_more_writes", log4.size() - base, 32'd16);
        check("fill_no_restart",     restarts4 - rbase,  32'd0);
        check("fill_err_held",       {31'd0, pl4.load_err}, 32'd1);
        start4();
        check("reload_err_clr", {31'd0, pl4.load_err},     32'd0);
        check("reload_stop",    {31'd0, pl4.cpu_stop},     32'd1);
        check("reload_words",   {27'd0, pl4.words_loaded}, 32'd0);
        base = log4.size();
        send4(8'h00);
        send4(8'h00);
        @(negedge clk);
        check("reload_nwrites", log4.size() - base, 32'd1);
        if (log4.size() > base) check("reload_write0", log4[base], 32'h0000_0000);
        check("reload_done", {31'd0, pl4.load_done}, 32'd1);

        // Abort: partial byte 0xAB is discarded.
        base = log8.size();
        start8();
        check("abort_done_clr", {31'd0, pl8.load_done}, 32'd0);
        send8(8'hAB);
        start8();
        send8(8'hCD);
        send8(8'hEF);
        send8(8'h00);
        send8(8'h00);
        @(negedge clk);
        check("abort_nwrites", log8.size() - base, 32'd2);
        if (log8.size() - base >= 2) begin
            check("abort_write0", log8[base],     32'h0000_CDEF);
            check("abort_write1", log8[base + 1], 32'h0001_0000);
        end
        check("abort_done", {31'd0, pl8.load_done}, 32'd1);

        // load_start and rx_done together: the byte is dropped.
        base = log8.size();
        rbase = restarts8;
        pl8.load_start = 1'b1;
        pl8.rx_done = 1'b1;
        pl8.rx_data = 8'h55;
        @(negedge clk);
        pl8.load_start = 1'b0;
        pl8.rx_done = 1'b0;
        send8(8'h00);
        send8(8'h00);
        @(negedge clk);
        check("coll_nwrites", log8.size() - base, 32'd1);
        if (log8.size() > base) check("coll_write0", log8[base], 32'h0000_0000);
        check("coll_restarts", restarts8 - rbase, 32'd1);
        check("coll_done", {31'd0, pl8.load_done}, 32'd1);

        // Asynchronous reset between bytes of the third word.
        start8();
        send8(8'h11);
        send8(8'h11);
        send8(8'h22);
        send8(8'h22);
        send8(8'h33);
        check("ar_words_before", {23'd0, pl8.words_loaded}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("ar_stop",    {31'd0, pl8.cpu_stop},     32'd0);
        check("ar_words",   {23'd0, pl8.words_loaded}, 32'd0);
        check("ar_addr",    {24'd0, pl8.mem_addr},     32'd0);
        check("ar_wdata",   {16'd0, pl8.mem_wdata},    32'd0);
        check("ar_restart", {31'd0, pl8.cpu_restart},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        base = log8.size();
        rbase = restarts8;
        send8(8'h00);
        send8(8'h00);
        send8(8'h00);
        @(negedge clk);
        check("ar_no_writes",   log8.size() - base,    32'd0);
        check("ar_no_restart",  restarts8 - rbase,     32'd0);
        check("ar_stop_after",  {31'd0, pl8.cpu_stop}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
